// File: rtl/bios_loader_ctrl.sv
// bios_loader_ctrl
// Copies the BIOS image from a byte-wide ROM into the system BIOS write port at power-up.
// Byte pairs are fetched (low byte first), packed little-endian into 16-bit words and
// offered to the system with a req/wr handshake. bios_loaded rises once the last word
// has been accepted and stays high until the next load or reset.
//
// Optional build macro: BIOS_LOADER_CHECKSUM_EN
//   Adds a running mod-2^16 sum of accepted words (checksum), a compare input
//   (expected_sum) and sum_ok, which is meaningful only in DONE.
module bios_loader_ctrl #(
    parameter int ROM_AW  = 14,    // ROM byte-address width
    parameter int WORDS   = 8192,  // 16-bit words to transfer
    parameter int ROM_LAT = 1      // ROM read latency in clk_sys cycles, 1..3
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              bios_req,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [12:0]       bios_addr,
    output logic [15:0]       bios_din,
    output logic              bios_wr,
    output logic              busy,
    output logic              bios_loaded
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    input  logic [15:0]       expected_sum,
    output logic [15:0]       checksum,
    output logic              sum_ok
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_WT_LO,
        S_RD_HI,
        S_WT_HI,
        S_PEND,
        S_WRITE,
        S_DONE
    } state_t;

    // Last value of the latency counter before the ROM byte is valid.
    localparam logic [1:0]  LAT_LAST = 2'(ROM_LAT - 1);
    // Word index whose acceptance completes the load.
    localparam logic [13:0] LAST_N   = 14'(WORDS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [13:0] r_n;        // index of the word being transferred
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [1:0]  r_lat;      // counts ROM latency cycles in WT_LO / WT_HI
    logic        r_loaded;
    logic        w_load_start;
    logic        w_accept;
    logic        w_lat_done;

    // A load may only begin from an idle or finished controller; start while busy is ignored.
    assign w_load_start = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept     = (r_state == S_WRITE) && bios_req;
    assign w_lat_done   = (r_lat == LAT_LAST);

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples values from before the edge, independent of block ordering.
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RD_LO;
            S_RD_LO: w_next = S_WT_LO;
            S_WT_LO: if (w_lat_done) w_next = S_RD_HI;
            S_RD_HI: w_next = S_WT_HI;
            S_WT_HI: if (w_lat_done) w_next = S_PEND;
            S_PEND:  if (bios_req) w_next = S_WRITE;
            S_WRITE: begin
                if (!bios_req)         w_next = S_PEND;   // retry same word, no ROM re-read
                else if (r_n == LAST_N) w_next = S_DONE;
                else                    w_next = S_RD_LO;
            end
            S_DONE:  if (start) w_next = S_RD_LO;
            default: w_next = S_IDLE;
        endcase
    end

    // Word counter, ROM latency counter, byte capture and completion flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            // NOTE: every datapath register is reset so all outputs read 0 in the
            // same cycle reset is asserted, and a partial load is discarded.
            r_n      <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_lat    <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (w_load_start) begin
                r_n      <= '0;
                r_loaded <= 1'b0;
            end else if (w_accept) begin
                r_n <= r_n + 14'd1;
                if (r_n == LAST_N) r_loaded <= 1'b1;
            end

            if (r_state == S_WT_LO || r_state == S_WT_HI) begin
                r_lat <= w_lat_done ? 2'd0 : r_lat + 2'd1;
            end

            if (r_state == S_WT_LO && w_lat_done) r_lo <= rom_data;
            if (r_state == S_WT_HI && w_lat_done) r_hi <= rom_data;
        end
    end

    // Output decode: strobes come straight from the state so they cannot leak into other states.
    always_comb begin
        rom_ce      = (r_state == S_RD_LO) || (r_state == S_RD_HI);
        rom_addr    = rom_ce ? ROM_AW'({r_n, r_state == S_RD_HI}) : '0;
        bios_addr   = r_n[12:0];
        bios_din    = {r_hi, r_lo};
        bios_wr     = (r_state == S_WRITE);
        busy        = (r_state != S_IDLE) && (r_state != S_DONE);
        bios_loaded = r_loaded;
    end

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [15:0] r_sum;

    // Running mod-2^16 sum of accepted words, cleared when a load begins.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_load_start) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + {r_hi, r_lo};
        end
    end

    assign checksum = r_sum;
    assign sum_ok   = (r_state == S_DONE) && (r_sum == expected_sum);
`endif

endmodule
